// File: rtl/w_serializer.sv
// rtl/w_serializer.sv - MSB-first word-to-bit serializer with programmable replay count
// Feeds the single-bit w stream of the sequence detectors, one bit per bit_en strobe.
module w_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   REP_W     = 4,
  parameter logic IDLE_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_rep,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bitcnt;
  logic [REP_W-1:0] repcnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);

  // shreg keeps the bit currently on w at its MSB, so the next bit is shreg[WIDTH-2].
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      shreg   <= '0;
      word    <= '0;
      bitcnt  <= '0;
      repcnt  <= '0;
      w       <= IDLE_FILL;
      w_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            word    <= in_data;
            bitcnt  <= LAST_BIT;
            repcnt  <= in_rep;
            w       <= in_data[WIDTH-1];
            w_valid <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (bitcnt != '0) begin
              shreg  <= {shreg[WIDTH-2:0], 1'b0};
              w      <= shreg[WIDTH-2];
              bitcnt <= bitcnt - 1'b1;
            end else if (repcnt != '0) begin
              shreg  <= word;
              w      <= word[WIDTH-1];
              bitcnt <= LAST_BIT;
              repcnt <= repcnt - 1'b1;
            end else begin
              w       <= IDLE_FILL;
              w_valid <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
